// File: rtl/axi_line_master_pkg.sv
// Shared types and AXI encodings for the line master.
// Holds the FSM state enum and the beat/burst constants.
package axi_line_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_DONE
    } state_t;

    localparam int BEAT_BYTES = 16;
    localparam int BEAT_BITS  = BEAT_BYTES * 8;

    localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_line_master_if.sv
// AXI read (AR/R) and write (AW/W/B) channel bundles.
// The master modport is the initiator side.
interface axir_if
    import axi_line_master_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                 arvalid;
    logic                 arready;
    logic [ADDR_W-1:0]    araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 rvalid;
    logic                 rready;
    logic [BEAT_BITS-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

interface axiw_if
    import axi_line_master_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_W-1:0]      awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   wvalid;
    logic                   wready;
    logic [BEAT_BITS-1:0]   wdata;
    logic [BEAT_BYTES-1:0]  wstrb;
    logic                   wlast;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_line_master.sv
// Cache-line AXI master: one refill or writeback burst at a time.
// Outputs are decoded from registered state, so VALIDs never see READYs.
module axi_line_master
    import axi_line_master_pkg::*;
#(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic                            i_req_write,
    input  logic [ADDR_W-1:0]               i_req_addr,
    input  logic [LINE_BEATS*BEAT_BITS-1:0] i_req_wdata,
    output logic                            o_rsp_valid,
    output logic [LINE_BEATS*BEAT_BITS-1:0] o_rsp_rdata,
    output logic                            o_rsp_err,
    axir_if.master                          ri,
    axiw_if.master                          wi
);

    localparam int LINE_W = LINE_BEATS * BEAT_BITS;
    localparam int OFF_W  = $clog2(LINE_BEATS * BEAT_BYTES);
    localparam int CNT_W  = $clog2(LINE_BEATS) + 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic                w_accept;
    logic                w_last;
    logic                w_r_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic [BEAT_BITS-1:0] w_wbeat;

    assign w_last = (r_cnt == CNT_W'(LINE_BEATS - 1));
    assign w_r_hs = (r_state == ST_RDATA) && ri.rvalid;
    assign w_w_hs = (r_state == ST_WDATA) && wi.wready;
    assign w_b_hs = (r_state == ST_WRESP) && wi.bvalid;

    assign ri.araddr  = r_addr;
    assign ri.arlen   = 8'(LINE_BEATS - 1);
    assign ri.arsize  = AXI_SIZE_16B;
    assign ri.arburst = AXI_BURST_INCR;

    assign wi.awaddr  = r_addr;
    assign wi.awlen   = 8'(LINE_BEATS - 1);
    assign wi.awsize  = AXI_SIZE_16B;
    assign wi.awburst = AXI_BURST_INCR;
    assign wi.wdata   = w_wbeat;
    assign wi.wstrb   = '1;
    assign wi.wlast   = w_last;

    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state and per-state channel strobes.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        ri.arvalid  = 1'b0;
        ri.rready   = 1'b0;
        wi.awvalid  = 1'b0;
        wi.wvalid   = 1'b0;
        wi.bready   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_req_ready = !i_rst;
                if (i_req_valid && !i_rst) begin
                    w_accept = 1'b1;
                    w_next   = i_req_write ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                ri.arvalid = 1'b1;
                if (ri.arready) w_next = ST_RDATA;
            end
            ST_RDATA: begin
                ri.rready = 1'b1;
                if (ri.rvalid && w_last) w_next = ST_DONE;
            end
            ST_WADDR: begin
                wi.awvalid = 1'b1;
                if (wi.awready) w_next = ST_WDATA;
            end
            ST_WDATA: begin
                wi.wvalid = 1'b1;
                if (wi.wready && w_last) w_next = ST_WRESP;
            end
            ST_WRESP: begin
                wi.bready = 1'b1;
                if (wi.bvalid) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_rsp_valid = 1'b1;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the aligned line address and writeback data on acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= {i_req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            r_wdata <= i_req_wdata;
        end
    end

    // Beat counter and sticky error; RLAST is checked, never trusted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_r_hs || w_w_hs) r_cnt <= r_cnt + 1'b1;
            if (w_r_hs && (ri.rresp != AXI_RESP_OKAY || ri.rlast != w_last))
                r_err <= 1'b1;
            if (w_b_hs && wi.bresp != AXI_RESP_OKAY)
                r_err <= 1'b1;
        end
    end

    // Refill beats land in their slot; the line holds until the next refill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (w_r_hs) begin
            for (int b = 0; b < LINE_BEATS; b++)
                if (r_cnt == CNT_W'(b))
                    r_rdata[b*BEAT_BITS +: BEAT_BITS] <= ri.rdata;
        end
    end

    // Select the writeback beat addressed by the counter.
    always_comb begin
        w_wbeat = '0;
        for (int b = 0; b < LINE_BEATS; b++)
            if (r_cnt == CNT_W'(b))
                w_wbeat = r_wdata[b*BEAT_BITS +: BEAT_BITS];
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master with a scripted AXI slave.
// Vector table covers refill/writeback variants; hand sequences cover reset and back-to-back.
module tb_axi_line_master;
    import axi_line_master_pkg::*;

    localparam int LB = 4;
    localparam int AW = 32;
    localparam int LW = LB * 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [LW-1:0] rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    axir_if #(.ADDR_W(AW)) ri ();
    axiw_if #(.ADDR_W(AW)) wi ();

    axi_line_master #(.LINE_BEATS(LB), .ADDR_W(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_write (req_write),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .ri          (ri),
        .wi          (wi)
    );

    function automatic logic [127:0] beat(input logic [7:0] tag, input int i);
        return {tag, 88'h0, 32'(i)};
    endfunction

    function automatic logic [LW-1:0] line(input logic [7:0] tag);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < LB; i++) l[i*128 +: 128] = beat(tag, i);
        return l;
    endfunction

    // slave configuration and logs
    logic [7:0]  s_tag = 8'h00;
    int          s_rlast_at = LB - 1;
    logic [1:0]  s_rresp = AXI_RESP_OKAY;
    logic [1:0]  s_bresp = AXI_RESP_OKAY;
    bit          s_wtog = 1'b0;

    logic [31:0] c_araddr, c_awaddr;
    logic [7:0]  c_arlen, c_awlen;
    logic [2:0]  c_arsize, c_awsize;
    logic [1:0]  c_arburst, c_awburst;
    int          n_ar = 0, n_aw = 0, n_r = 0, n_w = 0;
    logic [127:0] wlog [8];
    logic        wlast_log [8];
    int          viol_early_w = 0, viol_hold = 0, viol_overlap = 0;

    bit          rd_act = 1'b0;
    int          rd_idx = 0;
    bit          b_pend = 1'b0;
    bit          w_stall = 1'b0;
    logic [127:0] w_hold_d;
    logic        w_hold_l;

    initial begin
        ri.arready = 1'b1;
        ri.rvalid  = 1'b0;
        ri.rdata   = '0;
        ri.rresp   = AXI_RESP_OKAY;
        ri.rlast   = 1'b0;
        wi.awready = 1'b1;
        wi.wready  = 1'b1;
        wi.bvalid  = 1'b0;
        wi.bresp   = AXI_RESP_OKAY;
    end

    // Slave: observe handshakes at the edge, drive responses just after.
    always @(posedge clk) begin
        if (rst) begin
            rd_act  = 1'b0;
            b_pend  = 1'b0;
            w_stall = 1'b0;
        end else begin
            if (wi.wvalid && n_aw == 0) viol_early_w++;
            if ((ri.arvalid || ri.rready) && (wi.awvalid || wi.wvalid || wi.bready))
                viol_overlap++;
            if (ri.arvalid && ri.arready) begin
                c_araddr = ri.araddr; c_arlen = ri.arlen;
                c_arsize = ri.arsize; c_arburst = ri.arburst;
                n_ar++; rd_act = 1'b1; rd_idx = 0;
            end
            if (ri.rvalid && ri.rready) begin
                n_r++; rd_idx++;
                if (rd_idx == LB) rd_act = 1'b0;
            end
            if (wi.awvalid && wi.awready) begin
                c_awaddr = wi.awaddr; c_awlen = wi.awlen;
                c_awsize = wi.awsize; c_awburst = wi.awburst;
                n_aw++;
            end
            if (w_stall && (!wi.wvalid || wi.wdata != w_hold_d || wi.wlast != w_hold_l))
                viol_hold++;
            w_stall  = wi.wvalid && !wi.wready;
            w_hold_d = wi.wdata;
            w_hold_l = wi.wlast;
            if (wi.wvalid && wi.wready) begin
                if (n_w < 8) begin
                    wlog[n_w]      = wi.wdata;
                    wlast_log[n_w] = wi.wlast;
                end
                n_w++;
                if (wi.wlast) b_pend = 1'b1;
            end
            if (wi.bvalid && wi.bready) b_pend = 1'b0;
        end
        #1;
        ri.rvalid = rd_act;
        ri.rdata  = beat(s_tag, rd_idx);
        ri.rlast  = rd_act && (rd_idx == s_rlast_at);
        ri.rresp  = s_rresp;
        wi.bvalid = b_pend;
        wi.bresp  = s_bresp;
        wi.wready = s_wtog ? !wi.wready : 1'b1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [7:0]  tag;
        bit          wtog;
        int          rlast_at;
        logic [1:0]  rresp;
        logic [1:0]  bresp;
        logic [31:0] exp_addr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt [8];

    task automatic run_txn(input vec_t v, output int lat, output logic err, output logic seen);
        int k;
        s_tag = v.tag; s_rlast_at = v.rlast_at;
        s_rresp = v.rresp; s_bresp = v.bresp; s_wtog = v.wtog;
        n_ar = 0; n_aw = 0; n_r = 0; n_w = 0;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = line(v.tag);
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin step(); k++; end
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin step(); lat++; end
        seen = rsp_valid;
        err  = rsp_err;
        step();
    endtask

    logic [LW-1:0] last_line;
    int            lat;
    logic          err, seen;
    int            k, nseen;
    vec_t          v;

    initial begin
        vt[0] = '{1'b0, 32'h0000_1234, 8'hA0, 1'b0, 3, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_1200, 1'b0, 6};
        vt[1] = '{1'b1, 32'h0000_2040, 8'hD0, 1'b1, 3, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_2040, 1'b0, 0};
        vt[2] = '{1'b0, 32'h0000_3000, 8'hB0, 1'b0, 2, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_3000, 1'b1, 6};
        vt[3] = '{1'b1, 32'h0000_4050, 8'h40, 1'b0, 3, AXI_RESP_OKAY, AXI_RESP_SLVERR, 32'h0000_4040, 1'b1, 7};
        vt[4] = '{1'b0, 32'h0000_5FFF, 8'h50, 1'b0, 3, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_5FC0, 1'b0, 6};
        vt[5] = '{1'b0, 32'h0000_6010, 8'h60, 1'b0, 3, AXI_RESP_SLVERR, AXI_RESP_OKAY, 32'h0000_6000, 1'b1, 6};
        vt[6] = '{1'b1, 32'h0000_7000, 8'h70, 1'b0, 3, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_7000, 1'b0, 7};
        vt[7] = '{1'b0, 32'h0000_8000, 8'h80, 1'b0, 9, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_8000, 1'b1, 6};

        step(); step();
        chk("rst_strobes", {ri.arvalid, ri.rready, wi.awvalid, wi.wvalid, wi.bready, rsp_valid, req_ready}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1);
        last_line = '0;

        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            run_txn(v, lat, err, seen);
            chk($sformatf("v%0d_rsp_seen", i), seen, 1);
            if (v.exp_lat != 0) chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
            chk($sformatf("v%0d_rsp_err", i), err, v.exp_err);
            chk($sformatf("v%0d_pulse", i), rsp_valid, 0);
            if (v.write) begin
                chk($sformatf("v%0d_awaddr", i), c_awaddr, v.exp_addr);
                chk($sformatf("v%0d_awenc", i), {c_awlen, c_awsize, c_awburst}, {8'd3, 3'd4, 2'b01});
                chk($sformatf("v%0d_no_ar", i), n_ar, 0);
                chk($sformatf("v%0d_nw", i), n_w, 4);
                for (int b = 0; b < LB; b++) begin
                    chk($sformatf("v%0d_wdata%0d", i, b), wlog[b], beat(v.tag, b));
                    chk($sformatf("v%0d_wlast%0d", i, b), wlast_log[b], (b == LB - 1));
                end
                chk($sformatf("v%0d_rdata_hold", i), rsp_rdata, last_line);
            end else begin
                chk($sformatf("v%0d_araddr", i), c_araddr, v.exp_addr);
                chk($sformatf("v%0d_arenc", i), {c_arlen, c_arsize, c_arburst}, {8'd3, 3'd4, 2'b01});
                chk($sformatf("v%0d_no_aw", i), n_aw, 0);
                chk($sformatf("v%0d_nr", i), n_r, 4);
                chk($sformatf("v%0d_rdata", i), rsp_rdata, line(v.tag));
                last_line = line(v.tag);
            end
        end

        // reset in the middle of a refill burst
        s_tag = 8'hC0; s_rlast_at = 3; s_rresp = AXI_RESP_OKAY; s_wtog = 1'b0;
        n_ar = 0; n_aw = 0; n_r = 0; n_w = 0;
        req_write = 1'b0; req_addr = 32'h0000_9000; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin step(); k++; end
        step();
        req_valid = 1'b0;
        k = 0;
        while (n_r < 2 && k < 20) begin step(); k++; end
        chk("mid_two_beats", n_r, 2);
        rst = 1'b1;
        step();
        chk("mid_rst_strobes", {ri.arvalid, ri.rready, wi.awvalid, wi.wvalid, wi.bready, rsp_valid, req_ready}, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        nseen = 0;
        for (int c = 0; c < 2; c++) begin step(); if (rsp_valid) nseen++; end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin step(); if (rsp_valid) nseen++; end
        chk("mid_no_rsp", nseen, 0);
        v = '{1'b0, 32'h0000_9000, 8'hC8, 1'b0, 3, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0000_9000, 1'b0, 6};
        run_txn(v, lat, err, seen);
        chk("post_rst_seen", seen, 1);
        chk("post_rst_lat", lat, 6);
        chk("post_rst_err", err, 0);
        chk("post_rst_rdata", rsp_rdata, line(8'hC8));

        // back-to-back: refill then writeback with REQ_VALID held
        s_tag = 8'hE0; s_rlast_at = 3; s_bresp = AXI_RESP_OKAY;
        n_ar = 0; n_aw = 0; n_r = 0; n_w = 0;
        req_write = 1'b0; req_addr = 32'h0000_A000; req_wdata = line(8'hF0); req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin step(); k++; end
        step();
        k = 0;
        while (!rsp_valid && k < 60) begin step(); k++; end
        chk("b2b_first_rsp", rsp_valid, 1);
        chk("b2b_first_rdata", rsp_rdata, line(8'hE0));
        step();
        chk("b2b_ready", {req_ready, req_valid}, 2'b11);
        req_write = 1'b1; req_addr = 32'h0000_B000;
        step();
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 60) begin step(); k++; end
        chk("b2b_second_rsp", rsp_valid, 1);
        chk("b2b_second_err", rsp_err, 0);
        chk("b2b_awaddr", c_awaddr, 32'h0000_B000);
        chk("b2b_counts", {n_ar[7:0], n_aw[7:0], n_w[7:0]}, {8'd1, 8'd1, 8'd4});
        chk("b2b_wbeat3", wlog[3], beat(8'hF0, 3));
        step();

        chk("no_early_w", viol_early_w, 0);
        chk("w_held", viol_hold, 0);
        chk("no_overlap", viol_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_line_master.md
AXI_LINE_MASTER -- requirements
Module: axi_line_master

Interface
REQ-001 Parameters SHALL be: LINE_BEATS, default 4, 128-bit beats per line; ADDR_W, default 32, address width.
REQ-002 CLK  in  1  sole clock; all logic SHALL update on its rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 REQ_VALID  in  1  line request present.
REQ-005 REQ_READY  out  1  request accepted when REQ_VALID&&REQ_READY.
REQ-006 REQ_WRITE  in  1  1 = writeback, 0 = refill.
REQ-007 REQ_ADDR  in  ADDR_W  line address; low log2(LINE_BEATS*16) bits ignored.
REQ-008 REQ_WDATA  in  LINE_BEATS*128  writeback line; beat 0 = bits [127:0].
REQ-009 RSP_VALID  out  1  one-cycle completion pulse.
REQ-010 RSP_RDATA  out  LINE_BEATS*128  refill line, same beat order.
REQ-011 RSP_ERR  out  1  completion had non-OKAY response or RLAST mismatch; qualified by RSP_VALID.
REQ-012 RI  AXIR.init  -  AXI read initiator (AR*, R*).
REQ-013 WI  AXIW.init  -  AXI write initiator (AW*, W*, B*).

Function
REQ-014 FSM states SHALL be IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE; one request outstanding.
REQ-015 REQ_READY SHALL be 1 only in IDLE; acceptance SHALL latch REQ_ADDR (aligned), REQ_WDATA and REQ_WRITE, then go to WADDR if REQ_WRITE else RADDR.
REQ-016 RADDR: ARVALID=1, ARADDR=latched aligned address, ARLEN=LINE_BEATS-1, ARSIZE=16 bytes, ARBURST=INCR; on ar handshake go to RDATA.
REQ-017 RDATA: RREADY=1; each r handshake SHALL store RDATA into beat slot beat_cnt and increment beat_cnt; handshake with beat_cnt==LINE_BEATS-1 goes to DONE.
REQ-018 RLAST SHALL be 1 exactly on the final beat; RLAST early or missing SHALL set the error flag; beat counting alone ends the burst.
REQ-019 WADDR: AWVALID=1 with the same address/len/size/burst encoding; W SHALL NOT be driven before the aw handshake; then go to WDATA.
REQ-020 WDATA: WVALID=1, WDATA=beat beat_cnt of the latched line, WSTRB=all ones, WLAST=(beat_cnt==LINE_BEATS-1); after the handshake with WLAST go to WRESP.
REQ-021 WRESP: BREADY=1; on b handshake go to DONE.
REQ-022 Any RRESP or BRESP other than `AXI_RESP_OKAY SHALL set the sticky error flag, cleared on acceptance.
REQ-023 DONE: RSP_VALID=1 for exactly one cycle, RSP_ERR=error flag; then go to IDLE; RSP_RDATA SHALL hold until the next refill completes.
REQ-024 VALID outputs SHALL stay asserted with stable payload until their handshake; no combinational path from READY inputs to VALID outputs.
REQ-025 beat_cnt SHALL be log2(LINE_BEATS)+1 bits, reset to 0 on acceptance, and never wrap inside a burst.
REQ-026 Latency with an always-ready slave: refill SHALL take 1 (AR) + LINE_BEATS + 1 (DONE) cycles from acceptance; writeback 1 + LINE_BEATS + 1 + 1.

Reset
REQ-027 RST high SHALL force IDLE, beat_cnt=0, error flag=0, REQ_READY=0 while RST=1, all VALID/READY outputs=0 and RSP_RDATA=0, including mid-burst; the abandoned transaction SHALL NOT be completed.
REQ-028 REQ_READY SHALL rise the first cycle after RST deasserts.

Structure
REQ-029 FSM state enum, beat size (16), AXI burst/size codes and `AXI_RESP_OKAY SHALL reside in the shared defs/package, not locally.
REQ-030 Single flat module; no sub-module required.

Verification
REQ-031 Refill 0x0000_1234, slave always ready, beats A0..A3 -> ARADDR=0x0000_1200, ARLEN=3; RSP_VALID 6 cycles after acceptance; RSP_RDATA={A3,A2,A1,A0}; RSP_ERR=0.
REQ-032 Writeback 0x0000_2040 line {D3..D0}, WREADY toggling 1/0 -> AWADDR=0x0000_2040; W beats D0..D3 in order, held while stalled; WLAST only with D3; RSP_ERR=0.
REQ-033 Refill with RLAST on beat 2 -> 4 beats still accepted; RSP_ERR=1.
REQ-034 Writeback with BRESP=SLVERR -> RSP_VALID with RSP_ERR=1; next refill returns RSP_ERR=0.
REQ-035 RST asserted after the 2nd R beat -> next cycle all VALIDs=0 and no RSP_VALID; a new refill then completes correctly.
REQ-036 Back-to-back requests with REQ_VALID held -> second accepted the cycle after the first RSP_VALID; no AR/AW overlap.
